// File: rtl/pcs_tx_gearbox_ctrl.sv
// pcs_tx_gearbox_ctrl
//   Sequencer for the PCS TX path into the GTY 64b/66b synchronous gearbox.
//   It waits for the GTY reset-done plus a settle delay, then runs the TX
//   sequence counter. It also qualifies the header and data beats, and
//   back-pressures the encoder/scrambler on gearbox pause cycles.
//
//   Handshake: o_pcs_tx_ready is a zero-latency accept. The beat that upstream
//   presents in a cycle with o_pcs_tx_ready=1 is consumed by the gearbox in that
//   same cycle. While ready=0, upstream holds its data and its scrambler state.
//   o_pcs_tx_ready always equals o_tx_data_valid.
//
// Parameters
//   DATA_WIDTH  64 or 32. With 32, each 66b block spans two data beats.
//   SEQ_MAX     Sequence wrap value, 1..63. The beat with seq==SEQ_MAX is a pause.
//   INIT_DELAY  Number of settle cycles after i_gty_tx_rdy rises (>=1).
//
// Ports
//   i_clk            PCS TX clock (TXUSRCLK2 domain)
//   i_reset          synchronous, active-high reset
//   i_gty_tx_rdy     GTY TX reset-done; may drop at any time
//   o_tx_sequence    GTY TXSEQUENCE
//   o_tx_hdr_valid   sync header on this beat is valid
//   o_tx_data_valid  data beat consumed by the gearbox this cycle
//   o_pcs_tx_ready   accept strobe to the encoder/scrambler
//   o_running        high while in RUN
//   o_state          debug view of the FSM state (0 WAIT_RDY, 1 SETTLE, 2 RUN)
module pcs_tx_gearbox_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int SEQ_MAX    = 32,
  parameter int INIT_DELAY = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_gty_tx_rdy,
  output logic [5:0] o_tx_sequence,
  output logic       o_tx_hdr_valid,
  output logic       o_tx_data_valid,
  output logic       o_pcs_tx_ready,
  output logic       o_running,
  output logic [1:0] o_state
);

  generate
    if (SEQ_MAX < 1 || SEQ_MAX > 63) begin : g_bad_seq_max
      $error("pcs_tx_gearbox_ctrl: SEQ_MAX must be in 1..63");
    end
    if (DATA_WIDTH != 64 && DATA_WIDTH != 32) begin : g_bad_width
      $error("pcs_tx_gearbox_ctrl: DATA_WIDTH must be 32 or 64");
    end
    if (INIT_DELAY < 1) begin : g_bad_delay
      $error("pcs_tx_gearbox_ctrl: INIT_DELAY must be >= 1");
    end
  endgenerate

  localparam bit                IS_32    = (DATA_WIDTH == 32);
  localparam int                CNT_W    = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(INIT_DELAY - 1);
  localparam logic [5:0]        SEQ_LAST = 6'(SEQ_MAX);

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    SETTLE   = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;   // 32b only: 0 = first half of a block
  logic [5:0]       seq_d;
  logic             dv_d, hdr_d;

  // The next-state logic also computes next-cycle outputs, so every output is
  // a flop. Leaving RUN takes the zero defaults, which means no partial block
  // is completed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = 6'd0;
    phase_d = 1'b0;
    case (state_q)
      WAIT_RDY: begin
        if (i_gty_tx_rdy) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!i_gty_tx_rdy) begin
          state_d = WAIT_RDY;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;              // first RUN beat: seq 0, phase 0
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!i_gty_tx_rdy) begin
          state_d = WAIT_RDY;
        end else begin
          seq_d = (o_tx_sequence == SEQ_LAST) ? 6'd0 : o_tx_sequence + 6'd1;
          // The phase advances only on consumed beats, so a pause that falls
          // between the two halves of a block does not split the header.
          phase_d = (IS_32 && o_tx_data_valid) ? ~phase_q : phase_q;
        end
      end
      default: state_d = WAIT_RDY;
    endcase
    dv_d  = (state_d == RUN) && (seq_d != SEQ_LAST);
    hdr_d = dv_d && (!IS_32 || !phase_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= WAIT_RDY;
      cnt_q           <= '0;
      phase_q         <= 1'b0;
      o_tx_sequence   <= 6'd0;
      o_tx_hdr_valid  <= 1'b0;
      o_tx_data_valid <= 1'b0;
      o_pcs_tx_ready  <= 1'b0;
      o_running       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      phase_q         <= phase_d;
      o_tx_sequence   <= seq_d;
      o_tx_hdr_valid  <= hdr_d;
      o_tx_data_valid <= dv_d;
      o_pcs_tx_ready  <= dv_d;
      o_running       <= (state_d == RUN);
    end
  end

  assign o_state = state_q;

endmodule
